product_bcd_converter: RTL and testbench

- Downstream stage of the 8x8 signed shift-add multiplier.
- Accepts the multiplier's 16-bit two's-complement product when the multiplier's done pulse fires.
- Converts the product's magnitude to 5 BCD digits plus a negative flag, using a sequential double-dabble (shift/add-3) engine.
- Also produces a leading-zero blanking mask, so the 7-segment display driver can show the result directly.

---
 rtl/product_bcd_converter.sv | 122 ++++++++++++
 tb/tb_product_bcd_converter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/product_bcd_converter.sv
// Sequential double-dabble converter: turns the signed multiplier product into
// sign + BCD digits plus a leading-zero blanking mask for the display driver.
module product_bcd_converter #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      product,
   output logic                  busy,
   output logic                  done,
   output logic                  neg,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [DIGITS-1:0]     blank
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state_reg;
   state_t            state_next;

   logic [WIDTH-1:0]  mag_reg;
   logic [BW-1:0]     acc_reg;
   logic [CW-1:0]     cnt_reg;
   logic              neg_int_reg;
   logic [BW-1:0]     bcd_reg;
   logic              neg_reg;
   logic [DIGITS-1:0] blank_reg;

   logic              accept;
   logic              last_iter;
   logic [WIDTH-1:0]  mag_in;
   logic [BW-1:0]     acc_adj;
   logic [BW-1:0]     acc_shift;
   logic [DIGITS-1:0] digit_zero;
   logic [DIGITS-1:0] blank_calc;

   // A request is taken in IDLE and also in DONE so back-to-back products are not lost.
   assign accept    = start && ((state_reg == IDLE) || (state_reg == DONE));
   assign last_iter = (state_reg == SHIFT) && (cnt_reg == CW'(WIDTH - 1));

   // Unsigned magnitude: the most negative product maps to 2^(WIDTH-1) without overflow.
   assign mag_in = product[WIDTH-1] ? (~product + 1'b1) : product;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                     (acc_reg[4*gi +: 4] + 4'd3) :
                                     acc_reg[4*gi +: 4];
         assign digit_zero[gi] = (acc_shift[4*gi +: 4] == 4'd0);
      end
   endgenerate

   assign acc_shift = {acc_adj[BW-2:0], mag_reg[WIDTH-1]};

   // A digit is blanked only when it and every digit above it are zero; ones never blank.
   assign blank_calc[0] = 1'b0;
   generate
      for (gi = 1; gi < DIGITS; gi++) begin : g_blank
         assign blank_calc[gi] = &digit_zero[DIGITS-1:gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = SHIFT;
         SHIFT:   if (last_iter) state_next = DONE;
         DONE:    state_next = accept ? SHIFT : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mag_reg     <= '0;
         acc_reg     <= '0;
         cnt_reg     <= '0;
         neg_int_reg <= 1'b0;
         bcd_reg     <= '0;
         neg_reg     <= 1'b0;
         blank_reg   <= {{(DIGITS-1){1'b1}}, 1'b0};
      end else if (accept) begin
         mag_reg     <= mag_in;
         neg_int_reg <= product[WIDTH-1];
         acc_reg     <= '0;
         cnt_reg     <= '0;
      end else if (state_reg == SHIFT) begin
         acc_reg <= acc_shift;
         mag_reg <= {mag_reg[WIDTH-2:0], 1'b0};
         cnt_reg <= cnt_reg + 1'b1;
         // Visible results change only at the completion edge.
         if (last_iter) begin
            bcd_reg   <= acc_shift;
            neg_reg   <= neg_int_reg;
            blank_reg <= blank_calc;
         end
      end
   end

   always_comb begin
      busy  = (state_reg == SHIFT);
      done  = (state_reg == DONE);
      neg   = neg_reg;
      bcd   = bcd_reg;
      blank = blank_reg;
   end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed bench for product_bcd_converter: vector table plus hand-written
// sequences for ignored start, back-to-back start and reset mid-conversion.
module tb_product_bcd_converter;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] product;
   logic        busy;
   logic        done;
   logic        neg;
   logic [19:0] bcd;
   logic [4:0]  blank;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] p;
      logic [19:0] eb;
      logic        en;
      logic [4:0]  ebl;
   } vec_t;

   vec_t vecs [8];

   product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .product (product),
      .busy    (busy),
      .done    (done),
      .neg     (neg),
      .bcd     (bcd),
      .blank   (blank)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Presents start for one cycle; returns 1 time unit after the accepting edge.
   task automatic launch(input logic [15:0] p);
      @(negedge clk);
      product = p;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Called just after the accepting edge; optionally re-pulses start at edge inj_at.
   task automatic wait_done(input string nm, input logic [19:0] eb, input logic en,
                            input logic [4:0] ebl, input int inj_at, input logic [15:0] inj_p);
      int edges  = 0;
      int busy_n = 0;
      logic [19:0] hold;
      hold = bcd;
      while (!done && edges < 40) begin
         if (busy) busy_n++;
         if (edges == 8) chk({nm, " hold"}, 32'(bcd), 32'(hold));
         if (inj_at > 0 && edges == inj_at - 1) begin
            start   = 1'b1;
            product = inj_p;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         edges++;
      end
      start = 1'b0;
      chk({nm, " latency"}, 32'(edges), 32'd16);
      chk({nm, " busy_cycles"}, 32'(busy_n), 32'd16);
      chk({nm, " busy_at_done"}, 32'(busy), 32'd0);
      chk({nm, " bcd"}, 32'(bcd), 32'(eb));
      chk({nm, " neg"}, 32'(neg), 32'(en));
      chk({nm, " blank"}, 32'(blank), 32'(ebl));
      $display("conv %s: bcd=%05h neg=%b blank=%b after %0d edges", nm, bcd, neg, blank, edges);
   endtask

   initial begin
      int seen;

      vecs[0] = '{16'h0000, 20'h00000, 1'b0, 5'b11110};
      vecs[1] = '{16'h4000, 20'h16384, 1'b0, 5'b00000};
      vecs[2] = '{16'hC0FF, 20'h16129, 1'b1, 5'b00000};
      vecs[3] = '{16'h0009, 20'h00009, 1'b0, 5'b11110};
      vecs[4] = '{16'h8000, 20'h32768, 1'b1, 5'b00000};
      vecs[5] = '{16'hFFFF, 20'h00001, 1'b1, 5'b11110};
      vecs[6] = '{16'h0064, 20'h00100, 1'b0, 5'b11000};
      vecs[7] = '{16'h7FFF, 20'h32767, 1'b0, 5'b00000};

      reset   = 1'b1;
      start   = 1'b0;
      product = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset neg", 32'(neg), 32'd0);
      chk("reset bcd", 32'(bcd), 32'd0);
      chk("reset blank", 32'(blank), 32'(5'b11110));
      $display("reset: busy=%b done=%b bcd=%05h blank=%b", busy, done, bcd, blank);

      // Reset and start together: start must not be taken.
      @(negedge clk);
      start   = 1'b1;
      product = 16'h1234;
      @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      chk("rst_start busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_start busy2", 32'(busy), 32'd0);
      $display("reset+start: busy=%b", busy);

      for (int i = 0; i < 8; i++) begin
         launch(vecs[i].p);
         wait_done($sformatf("vec%0d", i), vecs[i].eb, vecs[i].en, vecs[i].ebl, 0, 16'h0000);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d done_pulse", i), 32'(done), 32'd0);
         chk($sformatf("vec%0d idle", i), 32'(busy), 32'd0);
      end

      // Start re-pulsed mid-conversion is ignored; start in DONE is accepted.
      launch(16'h0064);
      wait_done("ignored", 20'h00100, 1'b0, 5'b11000, 5, 16'h0001);
      product = 16'h0001;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b done_low", 32'(done), 32'd0);
      chk("b2b busy", 32'(busy), 32'd1);
      wait_done("b2b", 20'h00001, 1'b0, 5'b11110, 0, 16'h0000);
      @(posedge clk);
      #1;
      chk("b2b done_pulse", 32'(done), 32'd0);

      // Reset at cycle 8 of a conversion, with a negative result already displayed.
      launch(16'hC0FF);
      wait_done("pre_reset", 20'h16129, 1'b1, 5'b00000, 0, 16'h0000);
      @(posedge clk);
      #1;
      launch(16'h0064);
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst neg", 32'(neg), 32'd0);
      chk("midrst bcd", 32'(bcd), 32'd0);
      chk("midrst blank", 32'(blank), 32'(5'b11110));
      seen = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      chk("midrst no_done", 32'(seen), 32'd0);
      $display("mid reset: busy=%b bcd=%05h neg=%b done_seen=%0d", busy, bcd, neg, seen);

      launch(16'h03E8);
      wait_done("after_reset", 20'h01000, 1'b0, 5'b10000, 0, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
